imem_boot_ctrl: RTL and testbench

Boot and load sequencer for the instruction-fetch stage. It streams a program into instruction memory through its single write port. It shares that port with a debug writer and holds the fetch stage off while the load runs. It then redirects the PC to address 0 and releases the core. It sits between the off-chip loader/debug interface and `inst_fetch`, and drives that block's `write_en`, `write_addr`, `write_data`, `pc_sel` and `jump_addr`.

---
 rtl/imem_boot_pkg.sv | 17 +
 rtl/imem_boot_ctrl_wr_arb.sv | 49 ++++
 rtl/imem_boot_ctrl.sv | 134 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer.
package imem_boot_pkg;

    // Default instruction memory size and its capacity in 32-bit words.
    localparam int IMEM_BYTES_DEF = 2048;
    localparam int IMEM_WORDS     = IMEM_BYTES_DEF / 4;

    // Boot sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH0 = 3'd2,
        ST_FLUSH1 = 3'd3,
        ST_RUN    = 3'd4
    } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl_wr_arb.sv
// Fixed-priority write port arbiter (loader over debug) with the
// registered instruction-memory write stage.
module imem_wr_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            dbg_we,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_grant,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_wdata
);

    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_data;

    // Loader wins; debug only gets the port when the loader is not writing.
    always_comb begin
        dbg_grant = dbg_we && !ld_valid;
        sel_addr  = ld_addr;
        sel_data  = ld_data;
        if (!ld_valid) begin
            sel_addr = dbg_addr & ~(XLEN'(3));
            sel_data = dbg_data;
        end
    end

    // Register the winning write; address/data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= ld_valid || dbg_grant;
            if (ld_valid || dbg_grant) begin
                imem_addr  <= sel_addr;
                imem_wdata <= sel_data;
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load sequencer: streams a program into instruction memory, holds
// the fetch stage during the load, then redirects the PC to 0 and releases it.
// Handshake: a stream word transfers on a cycle where in_valid && in_ready;
// a debug write transfers on a cycle where dbg_we && dbg_grant, and an
// ungranted debug request must be held by the requester.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_BYTES = IMEM_WORDS * 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic [15:0]     load_len,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            dbg_we,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_grant,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_hold,
    output logic            pc_sel,
    output logic [XLEN-1:0] jump_addr,
    output logic            load_done,
    output logic            load_err,
    output logic            busy,
    output logic [2:0]      state_dbg
);

    localparam logic [15:0] CAP_WORDS = 16'(IMEM_BYTES / 4);

    boot_state_t     state_q, state_d;
    logic [XLEN-1:0] wptr_q, wptr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     eff_q, eff_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic            ld_valid;

    // Next-state, counters, capacity clamp and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        eff_d     = eff_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        core_hold = 1'b1;
        pc_sel    = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                core_hold = (state_q == ST_IDLE);
                if (load_start) begin
                    // Oversized loads are clamped so the address never wraps.
                    wptr_d  = '0;
                    cnt_d   = '0;
                    err_d   = (load_len > CAP_WORDS);
                    eff_d   = (load_len > CAP_WORDS) ? CAP_WORDS : load_len;
                    state_d = (load_len == 16'd0) ? ST_FLUSH0 : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wptr_d = wptr_q + XLEN'(4);
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == eff_q - 16'd1) begin
                        state_d = ST_FLUSH0;
                    end
                end
            end
            ST_FLUSH0: begin
                core_hold = 1'b0;
                pc_sel    = 1'b1;
                state_d   = ST_FLUSH1;
            end
            ST_FLUSH1: begin
                core_hold = 1'b0;
                load_done = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; busy is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            eff_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            eff_q   <= eff_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_RUN);
        end
    end

    assign ld_valid  = in_valid && in_ready;
    assign jump_addr = '0;
    assign load_err  = err_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

    imem_wr_arb #(.XLEN(XLEN)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_addr    (wptr_q),
        .ld_data    (in_data),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_grant  (dbg_grant),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata)
    );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: scoreboard of expected memory writes,
// monitor on the falling edge, driver tasks on the rising edge.
module tb_imem_boot_ctrl;
    import imem_boot_pkg::*;

    localparam int XLEN = 32;
    localparam int CAP  = 512;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_start = 1'b0;
    logic [15:0]     load_len = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            dbg_we = 1'b0;
    logic [XLEN-1:0] dbg_addr = '0;
    logic [XLEN-1:0] dbg_data = '0;
    logic            dbg_grant;
    logic            imem_we;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_wdata;
    logic            core_hold;
    logic            pc_sel;
    logic [XLEN-1:0] jump_addr;
    logic            load_done;
    logic            load_err;
    logic            busy;
    logic [2:0]      state_dbg;

    imem_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_grant  (dbg_grant),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .pc_sel     (pc_sel),
        .jump_addr  (jump_addr),
        .load_done  (load_done),
        .load_err   (load_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int checks = 0;
    int failures = 0;
    logic [2*XLEN-1:0] exp_q[$];     // {addr, data} in expected write order
    int done_cnt = 0;
    int writes_seen = 0;
    logic [XLEN-1:0] last_addr = '0;
    bit expect_flush_we = 1'b0;
    logic pc_prev = 1'b0;

    // Reference model of the load in progress
    bit model_loading = 1'b0;
    int ld_idx = 0;
    int ld_eff = 0;

    logic [XLEN-1:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare every registered memory write.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                writes_seen++;
                last_addr = imem_addr;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", imem_addr, imem_wdata);
                end else begin
                    logic [2*XLEN-1:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr, e[2*XLEN-1:XLEN]);
                    check("write_data", imem_wdata, e[XLEN-1:0]);
                end
            end
            if (pc_sel) begin
                check("flush_jump_addr", jump_addr, 32'h0);
                check("flush_writes_drained", exp_q.size(), 0);
                check("flush_last_we", {31'b0, imem_we}, {31'b0, expect_flush_we});
                check("flush_core_hold", {31'b0, core_hold}, 0);
            end
            if (load_done) begin
                done_cnt++;
                check("done_after_pc_sel", {31'b0, pc_prev}, 1);
                check("done_core_hold", {31'b0, core_hold}, 0);
            end
            pc_prev = pc_sel;
        end else begin
            pc_prev = 1'b0;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(int len);
        load_len   = 16'(len);
        load_start = 1'b1;
        ld_eff     = (len > CAP) ? CAP : len;
        ld_idx     = 0;
        tick();
        load_start = 1'b0;
        model_loading = (len > 0);
        expect_flush_we = (len > 0);
        check("load_err", {31'b0, load_err}, {31'b0, (len > CAP)});
        check("start_core_hold", {31'b0, core_hold}, {31'b0, (len > 0)});
        check("start_busy", {31'b0, busy}, 1);
    endtask

    task automatic drive_cycle(bit v, logic [31:0] d, bit dwe, logic [31:0] da, logic [31:0] dd);
        in_valid = v;
        in_data  = d;
        dbg_we   = dwe;
        dbg_addr = da;
        dbg_data = dd;
        #1;
        check("in_ready", {31'b0, in_ready}, {31'b0, model_loading});
        check("dbg_grant", {31'b0, dbg_grant}, {31'b0, (dwe && !(model_loading && v))});
        if (model_loading && v) begin
            exp_q.push_back({32'(4 * ld_idx), d});
            ld_idx++;
            if (ld_idx == ld_eff) model_loading = 1'b0;
        end else if (dwe) begin
            exp_q.push_back({da[31:2], 2'b00, dd});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dbg_we   = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == start) begin
            failures++;
            $display("FAIL load_done_timeout: got no pulse expected one within 20 cycles");
        end
        check("run_busy", {31'b0, busy}, 0);
        check("run_core_hold", {31'b0, core_hold}, 0);
        check("run_state", {29'b0, state_dbg}, 32'(ST_RUN));
    endtask

    task automatic run_random_load(int len, int pct, bit with_dbg);
        bit pend = 1'b0;
        logic [31:0] da = '0;
        logic [31:0] dd = '0;
        int guard = 0;
        start_load(len);
        while (model_loading && guard < 4000) begin
            bit v;
            bit dwe;
            guard++;
            v = ($urandom_range(99) < pct);
            if (!pend) begin
                dwe = with_dbg && ($urandom_range(3) == 0);
                da  = $urandom_range(0, 2047);
                dd  = $urandom;
            end else begin
                dwe = 1'b1;
            end
            pend = dwe && v;
            drive_cycle(v, $urandom, dwe, da, dd);
        end
        wait_done();
    endtask

    // Main stimulus
    initial begin
        int w0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k;

        // Reset held for 3 cycles, then released
        repeat (3) tick();
        check("rst_core_hold", {31'b0, core_hold}, 1);
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_imem_we", {31'b0, imem_we}, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_state", {29'b0, state_dbg}, 32'(ST_IDLE));
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_load_err", {31'b0, load_err}, 0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_core_hold", {31'b0, core_hold}, 1);
        check("post_rst_state", {29'b0, state_dbg}, 32'(ST_IDLE));
        check("post_rst_imem_we", {31'b0, imem_we}, 0);

        // Four-word program at full rate
        w0 = writes_seen;
        start_load(4);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, prog[i], 1'b0, 0, 0);
        wait_done();
        check("prog_write_count", writes_seen - w0, 4);
        check("prog_last_addr", last_addr, 32'hC);

        // Stalled stream with the valid pattern 1,0,0,1
        w0 = writes_seen;
        start_load(4);
        k = 0;
        while (model_loading && k < 40) begin
            drive_cycle(pat[k % 4], $urandom, 1'b0, 0, 0);
            k++;
        end
        wait_done();
        check("stall_write_count", writes_seen - w0, 4);

        // Directed arbitration: debug held off by the loader, then granted
        start_load(3);
        drive_cycle(1'b1, $urandom, 1'b1, 32'h100, 32'hDEADBEEF);
        drive_cycle(1'b0, $urandom, 1'b1, 32'h100, 32'hDEADBEEF);
        drive_cycle(1'b1, $urandom, 1'b0, 0, 0);
        drive_cycle(1'b1, $urandom, 1'b0, 0, 0);
        wait_done();

        // Randomized loads with competing debug traffic
        for (int n = 0; n < 6; n++) begin
            run_random_load($urandom_range(1, 20), $urandom_range(30, 100), 1'b1);
        end

        // Overflow: 600 words requested, clamped to capacity
        w0 = writes_seen;
        run_random_load(600, 100, 1'b0);
        check("ovf_write_count", writes_seen - w0, CAP);
        check("ovf_last_addr", last_addr, 32'h7FC);
        check("ovf_load_err_sticky", {31'b0, load_err}, 1);
        start_load(0);
        wait_done();
        check("restart_err_cleared", {31'b0, load_err}, 0);

        // Debug writes while running
        for (int n = 0; n < 12; n++) begin
            drive_cycle(1'b0, 0, ($urandom_range(1) == 1), $urandom_range(0, 2047), $urandom);
        end

        // Abort mid-load with reset, then restart the existing image
        start_load(4);
        drive_cycle(1'b1, $urandom, 1'b0, 0, 0);
        drive_cycle(1'b1, $urandom, 1'b0, 0, 0);
        drive_cycle(1'b0, 0, 1'b0, 0, 0);
        tick();
        reset = 1'b1;
        #1;
        model_loading = 1'b0;
        check("abort_state", {29'b0, state_dbg}, 32'(ST_IDLE));
        check("abort_core_hold", {31'b0, core_hold}, 1);
        check("abort_imem_we", {31'b0, imem_we}, 0);
        check("abort_in_ready", {31'b0, in_ready}, 0);
        check("abort_busy", {31'b0, busy}, 1);
        check("abort_queue_empty", exp_q.size(), 0);
        tick();
        reset = 1'b0;
        tick();
        w0 = writes_seen;
        start_load(0);
        wait_done();
        check("restart_no_writes", writes_seen - w0, 0);

        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
